// File: rtl/i2f_pkg.sv
// Shared definitions for the int2float_pipe converter: rounding-mode enum,
// index-width helper and the elaboration-time parameter legality check.
package i2f_pkg;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    // Width of a bit index into a w-bit word (never below 1 bit).
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Mantissa must fit inside the input, and every possible right shift
    // (IN_W - MANT_W at most) must be representable in the exponent field.
    function automatic bit params_ok(input int in_w, input int mant_w, input int exp_w);
        return (mant_w >= 1) && (in_w >= mant_w + 1) && (exp_w >= 1) &&
               (((2 ** exp_w) - 1) >= (in_w - mant_w));
    endfunction

endpackage

// File: rtl/i2f_lod.sv
// Combinational leading-one detector: index of the most significant set bit
// of data, plus a flag for an all-zero word (index reads 0 in that case).
module i2f_lod
    import i2f_pkg::*;
#(
    parameter int W   = 11,
    parameter int P_W = idx_width(W)
) (
    input  logic [W-1:0]   data,
    output logic [P_W-1:0] idx,
    output logic           zero
);

    // Scan upward so the highest set bit is the last one to win.
    // NOTE: every output gets a default before the loop; otherwise a path
    // that assigns nothing would infer a latch.
    always_comb begin
        idx  = '0;
        zero = (data == '0);
        for (int i = 0; i < W; i++) begin
            if (data[i]) idx = P_W'(i);
        end
    end

endmodule

// File: rtl/int2float_pipe.sv
// Two-stage pipelined integer-to-float converter with valid/ready on both
// sides. Stage 1 registers sign, magnitude and leading-one index; stage 2
// shifts, optionally rounds, and packs {s, e, m} into the output register.
// Build option: define I2F_ROUND_NEAREST_EN for round-to-nearest-even with
// exponent saturation; otherwise the mantissa is truncated and out_sat is 0.
module int2float_pipe
    import i2f_pkg::*;
#(
    parameter int IN_W   = 11,
    parameter int MANT_W = 4,
    parameter int EXP_W  = 3,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [MANT_W-1:0] out_m,
    output logic [EXP_W-1:0]  out_e,
    output logic              out_sat
);

    localparam int P_W   = idx_width(IN_W);
    localparam int EW_W  = P_W + 1;           // exponent plus room for a rounding carry
    localparam int E_MAX = (2 ** EXP_W) - 1;

`ifdef I2F_ROUND_NEAREST_EN
    localparam rnd_mode_e RND_MODE = RND_RNE;
`else
    localparam rnd_mode_e RND_MODE = RND_TRUNC;
`endif

    if (!params_ok(IN_W, MANT_W, EXP_W)) begin : g_param_err
        $error("int2float_pipe: exponent too narrow for IN_W/MANT_W");
    end

    // Stage-1 register
    logic              s1_valid;
    logic              s1_s;
    logic [IN_W-1:0]   s1_mag;
    logic [P_W-1:0]    s1_p;
    logic              s1_zero;

    // Handshake chain: a stage can load when empty or when it drains this cycle.
    logic s1_ready;
    logic s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // Sign and magnitude of the incoming word; the magnitude is IN_W bits
    // unsigned so the most negative input converts exactly.
    logic            in_s;
    logic [IN_W-1:0] in_mag;
    logic [P_W-1:0]  in_p;
    logic            in_zero;

    // Sign extraction and two's-complement negation for signed builds.
    always_comb begin
        in_s   = (SIGNED != 0) ? in_data[IN_W-1] : 1'b0;
        in_mag = in_s ? (~in_data + IN_W'(1)) : in_data;
    end

    i2f_lod #(.W(IN_W), .P_W(P_W)) u_lod (
        .data (in_mag),
        .idx  (in_p),
        .zero (in_zero)
    );

    // Stage 1: capture sign, magnitude and leading-one position.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: data registers are reset too, because zeroed outputs after reset
    // are part of the interface contract, not just a debug nicety.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_s     <= 1'b0;
            s1_mag   <= '0;
            s1_p     <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_s    <= in_s;
                s1_mag  <= in_mag;
                s1_p    <= in_p;
                s1_zero <= in_zero;
            end
        end
    end

    // Stage-2 datapath results
    logic [P_W-1:0]    sh;
    logic [MANT_W-1:0] m_n;
    logic [EW_W-1:0]   e_n;
    logic              sat_n;
    logic              guard;
    logic              sticky;

    // Normalise to MANT_W bits, then round-to-nearest-even when enabled.
    always_comb begin
        sh     = '0;
        m_n    = '0;
        e_n    = '0;
        sat_n  = 1'b0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (s1_p >= P_W'(MANT_W - 1)) sh = s1_p - P_W'(MANT_W - 1);
        m_n = MANT_W'(s1_mag >> sh);
        e_n = EW_W'(sh);
        if ((RND_MODE == RND_RNE) && (sh != '0)) begin
            guard  = s1_mag[sh - P_W'(1)];
            sticky = |(s1_mag & ((IN_W'(1) << (sh - P_W'(1))) - IN_W'(1)));
            if (guard && (sticky || m_n[0])) begin
                if (&m_n) begin
                    m_n = MANT_W'(1) << (MANT_W - 1);
                    e_n = e_n + EW_W'(1);
                end else begin
                    m_n = m_n + MANT_W'(1);
                end
            end
            if (int'(e_n) > E_MAX) begin
                e_n   = EW_W'(E_MAX);
                m_n   = '1;
                sat_n = 1'b1;
            end
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_m     <= '0;
            out_e     <= '0;
            out_sat   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_s   <= s1_s && !s1_zero;
                out_m   <= m_n;
                out_e   <= EXP_W'(e_n);
                out_sat <= sat_n;
            end
        end
    end

endmodule

// File: tb/tb_int2float_pipe.sv
// Scoreboard bench for int2float_pipe: one unsigned and one signed instance.
// Stimulus pushes hand-computed results into per-instance queues; monitors
// pop and compare on every output transfer and check stall stability.
module tb_int2float_pipe;

    localparam int IN_W   = 11;
    localparam int MANT_W = 4;
    localparam int EXP_W  = 3;

    typedef logic [MANT_W+EXP_W+1:0] res_t;   // {s, m, e, sat}

    logic clk = 1'b0;
    logic rst;

    logic              in_valid_u, in_ready_u, out_valid_u, out_ready_u;
    logic [IN_W-1:0]   in_data_u;
    logic              out_s_u, out_sat_u;
    logic [MANT_W-1:0] out_m_u;
    logic [EXP_W-1:0]  out_e_u;

    logic              in_valid_s, in_ready_s, out_valid_s, out_ready_s;
    logic [IN_W-1:0]   in_data_s;
    logic              out_s_s, out_sat_s;
    logic [MANT_W-1:0] out_m_s;
    logic [EXP_W-1:0]  out_e_s;

    int tests_run = 0;
    int fails     = 0;
    bit saw_bp    = 1'b0;
    res_t q_u[$];
    res_t q_s[$];

    always #5 clk = ~clk;

    int2float_pipe #(.IN_W(IN_W), .MANT_W(MANT_W), .EXP_W(EXP_W), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data_u),
        .out_valid(out_valid_u), .out_ready(out_ready_u),
        .out_s(out_s_u), .out_m(out_m_u), .out_e(out_e_u), .out_sat(out_sat_u)
    );

    int2float_pipe #(.IN_W(IN_W), .MANT_W(MANT_W), .EXP_W(EXP_W), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_s(out_s_s), .out_m(out_m_s), .out_e(out_e_s), .out_sat(out_sat_s)
    );

    function automatic res_t mk(input logic s, input int m, input int e, input logic sat);
        return {s, MANT_W'(m), EXP_W'(e), sat};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_u(input logic [IN_W-1:0] d, input res_t e);
        bit acc = 1'b0;
        in_valid_u = 1'b1;
        in_data_u  = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready_u;
            if (!acc) saw_bp = 1'b1;
            @(posedge clk);
            if (acc) q_u.push_back(e);
            #1;
        end
        in_valid_u = 1'b0;
        if (!acc) begin
            tests_run++;
            fails++;
            $display("FAIL u_send_timeout: word 0x%0h not accepted, expected acceptance", d);
        end
    endtask

    task automatic send_s(input logic [IN_W-1:0] d, input res_t e);
        bit acc = 1'b0;
        in_valid_s = 1'b1;
        in_data_s  = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready_s;
            @(posedge clk);
            if (acc) q_s.push_back(e);
            #1;
        end
        in_valid_s = 1'b0;
        if (!acc) begin
            tests_run++;
            fails++;
            $display("FAIL s_send_timeout: word 0x%0h not accepted, expected acceptance", d);
        end
    endtask

    // Monitor for the unsigned instance.
    initial begin : mon_u
        res_t got, held, exp_r;
        bit   stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {out_s_u, out_m_u, out_e_u, out_sat_u};
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("u_stall_hold", {out_valid_u, got}, {1'b1, held});
                if (out_valid_u && out_ready_u) begin
                    if (q_u.size() == 0) begin
                        tests_run++;
                        fails++;
                        $display("FAIL u_unexpected: got 0x%0h, expected no output", got);
                    end else begin
                        exp_r = q_u.pop_front();
                        check("u_result", got, exp_r);
                    end
                end
                stalled = out_valid_u && !out_ready_u;
                held    = got;
            end
        end
    end

    // Monitor for the signed instance.
    initial begin : mon_s
        res_t got, exp_r;
        forever begin
            @(negedge clk);
            got = {out_s_s, out_m_s, out_e_s, out_sat_s};
            if (!rst && out_valid_s && out_ready_s) begin
                if (q_s.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL s_unexpected: got 0x%0h, expected no output", got);
                end else begin
                    exp_r = q_s.pop_front();
                    check("s_result", got, exp_r);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        in_valid_u  = 1'b0;
        in_valid_s  = 1'b0;
        in_data_u   = '0;
        in_data_s   = '0;
        out_ready_u = 1'b1;
        out_ready_s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid_u", out_valid_u, 0);
        check("rst_out_valid_s", out_valid_s, 0);
        check("rst_outputs_u", {out_s_u, out_m_u, out_e_u, out_sat_u}, 0);
        rst = 1'b0;

        // Unsigned directed vectors
`ifdef I2F_ROUND_NEAREST_EN
        send_u(11'd100,  mk(0, 12, 3, 0));
        send_u(11'd108,  mk(0, 14, 3, 0));
        send_u(11'd2047, mk(0, 15, 7, 1));
`else
        send_u(11'd100,  mk(0, 12, 3, 0));
        send_u(11'd108,  mk(0, 13, 3, 0));
        send_u(11'd2047, mk(0, 15, 7, 0));
`endif

        // Signed directed vectors
        send_s(-11'sd5,    mk(1, 5, 0, 0));
        send_s(-11'sd1024, mk(1, 8, 7, 0));
        send_s(11'd0,      mk(0, 0, 0, 0));
        send_s(-11'sd1,    mk(1, 1, 0, 0));
        send_s(11'd7,      mk(0, 7, 0, 0));
`ifdef I2F_ROUND_NEAREST_EN
        send_s(11'd1023,   mk(0, 8, 7, 0));
`else
        send_s(11'd1023,   mk(0, 15, 6, 0));
`endif

        // Back-to-back burst with a 3-cycle downstream stall in the middle
        saw_bp = 1'b0;
        fork
            begin
                send_u(11'd0,  mk(0, 0, 0, 0));
                send_u(11'd1,  mk(0, 1, 0, 0));
                send_u(11'd7,  mk(0, 7, 0, 0));
                send_u(11'd8,  mk(0, 8, 0, 0));
                send_u(11'd15, mk(0, 15, 0, 0));
                send_u(11'd16, mk(0, 8, 1, 0));
`ifdef I2F_ROUND_NEAREST_EN
                send_u(11'd31, mk(0, 8, 2, 0));
`else
                send_u(11'd31, mk(0, 15, 1, 0));
`endif
                send_u(11'd64, mk(0, 8, 3, 0));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready_u = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready_u = 1'b1;
            end
        join
        check("burst_in_ready_dropped", saw_bp, 1);
        for (int n = 0; n < 100 && q_u.size() != 0; n++) @(posedge clk);
        #1;

        // Reset with two words in flight: both must be discarded
        send_u(11'd500,  mk(0, 15, 5, 0));
        send_u(11'd1000, mk(0, 15, 6, 0));
        rst = 1'b1;
        #1;
        check("midrst_out_valid_u", out_valid_u, 0);
        check("midrst_outputs_u", {out_s_u, out_m_u, out_e_u, out_sat_u}, 0);
        check("midrst_in_ready_u", in_ready_u, 1);
        q_u.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send_u(11'd200, mk(0, 12, 4, 0));

        // Drain everything still expected
        for (int n = 0; n < 100 && (q_u.size() != 0 || q_s.size() != 0); n++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("u_drained", q_u.size(), 0);
        check("s_drained", q_s.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
